// File: rtl/ram_controller.sv
// ============================================================================
// ram_controller : burst master for a single-port synchronous RAM with a
//                  bidirectional data bus (line write / pipelined line read)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ram_controller #(
  parameter int ADDRESS_SIZE  = 11,
  parameter int MEM_WORD_SIZE = 64,
  parameter int BURST_LEN     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               reqValid,
  output logic                               reqReady,
  input  logic                               reqWrite,
  input  logic [ADDRESS_SIZE-1:0]            reqAddress,
  input  logic [BURST_LEN*MEM_WORD_SIZE-1:0] reqLine,
  output logic                               rdValid,
  output logic [MEM_WORD_SIZE-1:0]           rdData,
  output logic                               rdLast,
  output logic                               done,
  output logic [ADDRESS_SIZE-1:0]            memAddress,
  output logic                               memIsReading,
  inout  wire  [MEM_WORD_SIZE-1:0]           memData
);

  localparam int BEAT_W = $clog2(BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]                         state_q, state_d;
  logic [BEAT_W-1:0]                  beat_q, beat_d;
  logic [ADDRESS_SIZE-1:0]            base_q, base_d;
  logic [BURST_LEN*MEM_WORD_SIZE-1:0] line_q, line_d;
  logic                               cap_q;
  logic                               cap_last_q;
  logic                               rd_valid_q;
  logic                               rd_last_q;
  logic [MEM_WORD_SIZE-1:0]           rd_data_q;
  logic                               done_q;
  logic [MEM_WORD_SIZE-1:0]           w_word;
  logic                               w_last_beat;

  assign w_last_beat  = (beat_q == LAST_BEAT);
  assign w_word       = line_q[beat_q*MEM_WORD_SIZE +: MEM_WORD_SIZE];
  assign memAddress   = base_q + ADDRESS_SIZE'(beat_q);
  // Reset forces read mode immediately so an interrupted burst commits no further word.
  assign memIsReading = ~((state_q == S_WRITE) & ~reset);
  assign memData      = memIsReading ? {MEM_WORD_SIZE{1'bz}} : w_word;
  assign reqReady     = (state_q == S_IDLE) & ~reset;

  assign rdValid = rd_valid_q;
  assign rdLast  = rd_last_q;
  assign rdData  = rd_data_q;
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          base_d  = reqAddress;
          line_d  = reqLine;
          beat_d  = '0;
          state_d = reqWrite ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_last_beat) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_READ: begin
        // Beat is held on the last address so the drain cycle keeps it on the bus.
        if (w_last_beat) state_d = S_DRAIN;
        else             beat_d  = beat_q + 1'b1;
      end
      default: begin
        beat_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      line_q     <= '0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      line_q     <= line_d;
      // The RAM answers one cycle after the address, so capture trails issue by one.
      cap_q      <= (state_q == S_READ);
      cap_last_q <= (state_q == S_READ) & w_last_beat;
      rd_valid_q <= cap_q;
      rd_last_q  <= cap_last_q;
      if (cap_q) rd_data_q <= memData;
      done_q     <= ((state_q == S_WRITE) & w_last_beat) | cap_last_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_controller.sv
// ============================================================================
// tb_ram_controller : directed self-checking bench with a behavioural RAM
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_ram_controller;

  localparam int AW = 11;
  localparam int W  = 64;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            reqValid = 1'b0;
  logic            reqReady;
  logic            reqWrite = 1'b0;
  logic [AW-1:0]   reqAddress = '0;
  logic [BL*W-1:0] reqLine = '0;
  logic            rdValid;
  logic [W-1:0]    rdData;
  logic            rdLast;
  logic            done;
  logic [AW-1:0]   memAddress;
  logic            memIsReading;
  wire  [W-1:0]    memData;

  int checks = 0;
  int errors = 0;

  ram_controller #(.ADDRESS_SIZE(AW), .MEM_WORD_SIZE(W), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddress(reqAddress), .reqLine(reqLine),
    .rdValid(rdValid), .rdData(rdData), .rdLast(rdLast), .done(done),
    .memAddress(memAddress), .memIsReading(memIsReading), .memData(memData)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on posedge when not reading, registered read.
  logic [W-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  logic [W-1:0] ram_rd_q = '0;
  always @(posedge clk) begin
    if (!memIsReading) mem[memAddress] <= memData;
    else               ram_rd_q <= mem[memAddress];
  end
  assign memData = memIsReading ? ram_rd_q : {W{1'bz}};

  // Per-cycle observations of one burst, cycle 0 = first cycle after accept.
  logic          cv  [0:7];
  logic [W-1:0]  cd  [0:7];
  logic          cl  [0:7];
  logic          cdn [0:7];
  logic [AW-1:0] ca  [0:7];
  logic          cr  [0:7];
  logic [W-1:0]  cw  [0:7];
  logic          crdy[0:7];
  logic [W-1:0]  snap [0:(1<<AW)-1];

  function automatic logic [BL*W-1:0] make_line(input logic [W-1:0] b);
    logic [BL*W-1:0] l;
    for (int i = 0; i < BL; i++) l[i*W +: W] = b + W'(i);
    return l;
  endfunction

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      if (c != 0) @(negedge clk);
      cv[c] = rdValid; cd[c] = rdData; cl[c] = rdLast; cdn[c] = done;
      ca[c] = memAddress; cr[c] = memIsReading; cw[c] = memData; crdy[c] = reqReady;
    end
  endtask

  // Present a request at a negedge; returns at the negedge of cycle 0.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [BL*W-1:0] l);
    int n = 0;
    reqWrite = wr; reqAddress = a; reqLine = l; reqValid = 1'b1;
    while (!reqReady && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: reqReady %b required 1 (timeout)", reqReady);
    end
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", reqReady); end
    checks++; if (memIsReading !== 1'b1) begin errors++; $display("FAIL rst_rd: got %b want 1", memIsReading); end
    checks++; if (memAddress !== 11'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", memAddress); end
    checks++; if ({rdValid, rdLast, done} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {rdValid, rdLast, done}); end
    checks++; if (rdData !== 64'h0) begin errors++; $display("FAIL rst_data: got %h want 0", rdData); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", reqReady); end
  endtask

  task automatic test_write_read(input logic [AW-1:0] a, input logic [W-1:0] b, input string tag);
    issue(1'b1, a, make_line(b));
    capture(BL + 1);
    for (int c = 0; c < BL; c++) begin
      checks++; if (cr[c] !== 1'b0) begin errors++; $display("FAIL %s_wr_en c%0d: got %b want 0", tag, c, cr[c]); end
      checks++; if (ca[c] !== AW'(a + AW'(c))) begin errors++; $display("FAIL %s_wr_addr c%0d: got %h want %h", tag, c, ca[c], AW'(a + AW'(c))); end
      checks++; if (cw[c] !== b + W'(c)) begin errors++; $display("FAIL %s_wr_data c%0d: got %h want %h", tag, c, cw[c], b + W'(c)); end
      checks++; if (cdn[c] !== 1'b0) begin errors++; $display("FAIL %s_wr_early_done c%0d: got %b want 0", tag, c, cdn[c]); end
    end
    checks++; if (cdn[BL] !== 1'b1) begin errors++; $display("FAIL %s_wr_done: got %b want 1", tag, cdn[BL]); end
    checks++; if (cr[BL] !== 1'b1) begin errors++; $display("FAIL %s_wr_release: got %b want 1", tag, cr[BL]); end
    for (int i = 0; i < BL; i++) begin
      checks++;
      if (mem[AW'(a + AW'(i))] !== b + W'(i)) begin
        errors++; $display("FAIL %s_ram_word%0d: got %h want %h", tag, i, mem[AW'(a + AW'(i))], b + W'(i));
      end
    end
    issue(1'b0, a, '0);
    capture(BL + 2);
    for (int c = 0; c < BL + 2; c++) begin
      checks++; if (cr[c] !== 1'b1) begin errors++; $display("FAIL %s_rd_en c%0d: got %b want 1", tag, c, cr[c]); end
      checks++; if (cv[c] !== (c >= 2)) begin errors++; $display("FAIL %s_rd_valid c%0d: got %b want %b", tag, c, cv[c], c >= 2); end
      checks++; if (cl[c] !== (c == BL + 1)) begin errors++; $display("FAIL %s_rd_last c%0d: got %b want %b", tag, c, cl[c], c == BL + 1); end
      checks++; if (cdn[c] !== (c == BL + 1)) begin errors++; $display("FAIL %s_rd_done c%0d: got %b want %b", tag, c, cdn[c], c == BL + 1); end
      if (c >= 2) begin
        checks++; if (cd[c] !== b + W'(c - 2)) begin errors++; $display("FAIL %s_rd_data c%0d: got %h want %h", tag, c, cd[c], b + W'(c - 2)); end
      end
    end
    checks++; if (ca[BL] !== AW'(a + AW'(BL - 1))) begin errors++; $display("FAIL %s_drain_addr: got %h want %h", tag, ca[BL], AW'(a + AW'(BL - 1))); end
  endtask

  task automatic test_idle();
    int diffs = 0;
    for (int i = 0; i < (1 << AW); i++) snap[i] = mem[i];
    reqValid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      reqLine = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      reqWrite = 1'b1;
      @(negedge clk);
      checks++; if (memIsReading !== 1'b1) begin errors++; $display("FAIL idle_rd c%0d: got %b want 1", c, memIsReading); end
    end
    for (int i = 0; i < (1 << AW); i++) if (mem[i] !== snap[i]) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL idle_ram: %0d words changed, want 0", diffs); end
  endtask

  task automatic test_back_to_back();
    reqWrite = 1'b0; reqAddress = 11'h010; reqValid = 1'b1;
    @(negedge clk);
    reqWrite = 1'b1; reqAddress = 11'h300; reqLine = make_line(64'hD0);
    capture(BL + 2);
    for (int c = 0; c < BL + 2; c++) begin
      checks++; if (crdy[c] !== (c == BL + 1)) begin errors++; $display("FAIL b2b_ready c%0d: got %b want %b", c, crdy[c], c == BL + 1); end
    end
    for (int c = 0; c < BL; c++) begin
      checks++; if (ca[c] !== 11'h010 + AW'(c)) begin errors++; $display("FAIL b2b_rd_addr c%0d: got %h want %h", c, ca[c], 11'h010 + AW'(c)); end
      checks++; if (cd[c + 2] !== 64'hA0 + W'(c)) begin errors++; $display("FAIL b2b_rd_data c%0d: got %h want %h", c, cd[c + 2], 64'hA0 + W'(c)); end
    end
    checks++; if (cdn[BL + 1] !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", cdn[BL + 1]); end
    @(negedge clk);
    reqValid = 1'b0;
    checks++; if (memIsReading !== 1'b0) begin errors++; $display("FAIL b2b_next_wr: got %b want 0", memIsReading); end
    checks++; if (memAddress !== 11'h300) begin errors++; $display("FAIL b2b_next_addr: got %h want 300", memAddress); end
    repeat (BL) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_wr_done: got %b want 1", done); end
    checks++; if (mem[11'h303] !== 64'hD3) begin errors++; $display("FAIL b2b_ram: got %h want d3", mem[11'h303]); end
  endtask

  task automatic test_reset_midburst();
    int pulses = 0;
    issue(1'b1, 11'h100, make_line(64'hB0));
    repeat (BL) @(negedge clk);
    issue(1'b1, 11'h100, make_line(64'hC0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (memIsReading !== 1'b1) begin errors++; $display("FAIL mid_rst_rd: got %b want 1", memIsReading); end
    checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", reqReady); end
    @(negedge clk);
    checks++; if (memAddress !== 11'h0) begin errors++; $display("FAIL mid_rst_addr: got %h want 0", memAddress); end
    checks++; if ({rdValid, rdLast, done} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags: got %b want 000", {rdValid, rdLast, done}); end
    checks++; if (rdData !== 64'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", rdData); end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_rst_done: %0d pulses want 0", pulses); end
    checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b want 1", reqReady); end
    checks++; if (mem[11'h100] !== 64'hC0 || mem[11'h101] !== 64'hC1) begin errors++; $display("FAIL mid_rst_committed: got %h %h want c0 c1", mem[11'h100], mem[11'h101]); end
    checks++; if (mem[11'h102] !== 64'hB2 || mem[11'h103] !== 64'hB3) begin errors++; $display("FAIL mid_rst_kept: got %h %h want b2 b3", mem[11'h102], mem[11'h103]); end
  endtask

  task automatic test_read_write_read();
    issue(1'b0, 11'h020, '0);
    capture(BL + 2);
    checks++; if (cd[2] !== 64'h0) begin errors++; $display("FAIL rwr_first: got %h want 0", cd[2]); end
    issue(1'b1, 11'h020, make_line(64'h55));
    checks++; if (memIsReading !== 1'b0 || memData !== 64'h55) begin errors++; $display("FAIL rwr_turn: rd %b data %h want 0 55", memIsReading, memData); end
    capture(BL + 1);
    checks++; if (cdn[BL] !== 1'b1) begin errors++; $display("FAIL rwr_wr_done: got %b want 1", cdn[BL]); end
    issue(1'b0, 11'h020, '0);
    capture(BL + 2);
    checks++; if (cd[2] !== 64'h55) begin errors++; $display("FAIL rwr_second: got %h want 55", cd[2]); end
    checks++; if (cv[2] !== 1'b1) begin errors++; $display("FAIL rwr_second_valid: got %b want 1", cv[2]); end
  endtask

  initial begin
    test_reset();
    test_write_read(11'h010, 64'hA0, "basic");
    test_write_read(11'h7FE, 64'hE0, "wrap");
    test_idle();
    test_back_to_back();
    test_reset_midburst();
    test_read_write_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
